// File: rtl/key_repeat_pkg.sv
// Shared types and default timing for the typematic key handler.
// Defaults assume a 50 MHz clock.
package key_repeat_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT,
        WAIT_REL
    } rep_state_e;

    localparam int unsigned CLK_HZ            = 50_000_000;
    localparam int unsigned DEF_DEBOUNCE_CYC  = CLK_HZ / 200;
    localparam int unsigned DEF_INIT_DELAY    = CLK_HZ / 10 * 3;
    localparam int unsigned DEF_REPEAT_PERIOD = CLK_HZ / 10;
    localparam int unsigned DEF_REPEAT_FAST   = CLK_HZ / 20;
    localparam int unsigned DEF_ACCEL_AFTER   = 8;

endpackage

// File: rtl/key_debounce.sv
// One channel: synchroniser plus debounce counter.
// Ports: clk, RST (async low), key_raw in; held (stable level), rise (1-cycle, with held rise).
module key_debounce
    import key_repeat_pkg::*;
#(
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic RST,
    input  logic key_raw,
    output logic held,
    output logic rise
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       dcnt_q, dcnt_d;
    logic                   held_q, held_d;
    logic                   rise_q, rise_d;
    logic                   sync;

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], key_raw};
        held_d = held_q;
        dcnt_d = '0;
        rise_d = 1'b0;
        if (sync != held_q) begin
            if (dcnt_q == DB_LAST) begin
                held_d = sync;
                rise_d = sync;
            end else begin
                dcnt_d = dcnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            sync_q <= '0;
            dcnt_q <= '0;
            held_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            dcnt_q <= dcnt_d;
            held_q <= held_d;
            rise_q <= rise_d;
        end
    end

    assign held = held_q;
    assign rise = rise_q;

endmodule

// File: rtl/key_repeat.sv
// Multi-channel typematic key handler: debounce, press pulse, then timed repeats.
// Ports: clk, RST (async low), en, key_push[N] in; out[N] pulses, held[N] levels. Macro KEY_REPEAT_ACCEL_EN.
module key_repeat
    import key_repeat_pkg::*;
#(
    parameter int unsigned N_KEYS        = 4,
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
    parameter int unsigned INIT_DELAY    = DEF_INIT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter int unsigned ACCEL_AFTER   = DEF_ACCEL_AFTER,
    parameter int unsigned REPEAT_FAST   = DEF_REPEAT_FAST
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              en,
    input  logic [N_KEYS-1:0] key_push,
    output logic [N_KEYS-1:0] out,
    output logic [N_KEYS-1:0] held
);

    localparam longint unsigned CNT_MAX =
        (CNT_W >= 64) ? ~64'd0 : ((64'd1 << CNT_W) - 64'd1);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYC < 1 || INIT_DELAY < 1 ||
        REPEAT_PERIOD < 1 || REPEAT_FAST < 1 ||
        DEBOUNCE_CYC > CNT_MAX || INIT_DELAY > CNT_MAX ||
        REPEAT_PERIOD > CNT_MAX || REPEAT_FAST > CNT_MAX ||
        ACCEL_AFTER > CNT_MAX) begin : g_bad_cfg
        $error("key_repeat: illegal parameter set");
    end

    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_DELAY - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
`ifdef KEY_REPEAT_ACCEL_EN
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(REPEAT_FAST - 1);
    localparam int unsigned      PCNT_W    = $clog2(ACCEL_AFTER + 2);
    localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(ACCEL_AFTER);
`endif

    logic [N_KEYS-1:0] rise;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        rep_state_e       state_q, state_d;
        logic [CNT_W-1:0] rcnt_q, rcnt_d;
        logic [CNT_W-1:0] rep_last;
        logic             pulse_q, pulse_d;

        key_debounce #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_db (
            .clk    (clk),
            .RST    (RST),
            .key_raw(key_push[g]),
            .held   (held[g]),
            .rise   (rise[g])
        );

`ifdef KEY_REPEAT_ACCEL_EN
        logic [PCNT_W-1:0] pcnt_q, pcnt_d;
        assign rep_last = (pcnt_q == PCNT_MAX) ? FAST_LAST : REP_LAST;
`else
        assign rep_last = REP_LAST;
`endif

        always_comb begin
            state_d = state_q;
            rcnt_d  = rcnt_q;
            pulse_d = 1'b0;
`ifdef KEY_REPEAT_ACCEL_EN
            pcnt_d  = pcnt_q;
`endif
            if (!en) begin
                // A key still down must be released before it can fire again.
                rcnt_d  = '0;
                state_d = held[g] ? WAIT_REL : IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (rise[g]) begin
                            pulse_d = 1'b1;
                            rcnt_d  = '0;
                            state_d = DELAY;
`ifdef KEY_REPEAT_ACCEL_EN
                            pcnt_d  = '0;
`endif
                        end
                    end
                    DELAY: begin
                        if (!held[g]) begin
                            rcnt_d  = '0;
                            state_d = IDLE;
                        end else if (rcnt_q == INIT_LAST) begin
                            pulse_d = 1'b1;
                            rcnt_d  = '0;
                            state_d = REPEAT;
                        end else begin
                            rcnt_d = rcnt_q + CNT_W'(1);
                        end
                    end
                    REPEAT: begin
                        if (!held[g]) begin
                            rcnt_d  = '0;
                            state_d = IDLE;
                        end else if (rcnt_q == rep_last) begin
                            pulse_d = 1'b1;
                            rcnt_d  = '0;
`ifdef KEY_REPEAT_ACCEL_EN
                            if (pcnt_q != PCNT_MAX) begin
                                pcnt_d = pcnt_q + PCNT_W'(1);
                            end
`endif
                        end else begin
                            rcnt_d = rcnt_q + CNT_W'(1);
                        end
                    end
                    WAIT_REL: begin
                        if (!held[g]) begin
                            state_d = IDLE;
                        end
                    end
                    default: begin
                        rcnt_d  = '0;
                        state_d = IDLE;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or negedge RST) begin
            if (!RST) begin
                state_q <= IDLE;
                rcnt_q  <= '0;
                pulse_q <= 1'b0;
`ifdef KEY_REPEAT_ACCEL_EN
                pcnt_q  <= '0;
`endif
            end else begin
                state_q <= state_d;
                rcnt_q  <= rcnt_d;
                pulse_q <= pulse_d;
`ifdef KEY_REPEAT_ACCEL_EN
                pcnt_q  <= pcnt_d;
`endif
            end
        end

        assign out[g] = pulse_q;
    end

endmodule

// File: tb/tb_key_repeat.sv
// Self-checking bench for key_repeat: directed scenarios plus random
// key/enable traffic against a cycle-time reference model.
module tb_key_repeat;

    localparam int N     = 2;
    localparam int SYNC  = 2;
    localparam int DB    = 4;
    localparam int INIT  = 10;
    localparam int RP    = 5;
    localparam int ACCEL = 2;
    localparam int FAST  = 3;

    logic         clk = 1'b0;
    logic         RST = 1'b1;
    logic         en  = 1'b0;
    logic [N-1:0] key_push = '0;
    logic [N-1:0] out;
    logic [N-1:0] held;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    key_repeat #(
        .N_KEYS       (N),
        .CNT_W        (8),
        .SYNC_STAGES  (SYNC),
        .DEBOUNCE_CYC (DB),
        .INIT_DELAY   (INIT),
        .REPEAT_PERIOD(RP),
        .ACCEL_AFTER  (ACCEL),
        .REPEAT_FAST  (FAST)
    ) dut (
        .clk     (clk),
        .RST     (RST),
        .en      (en),
        .key_push(key_push),
        .out     (out),
        .held    (held)
    );

    // Reference model: held flips after the synchronised input has differed
    // for DB consecutive cycles; pulses are scheduled by elapsed time since
    // the press pulse.
    logic [N-1:0] raw_q[$];
    logic [N-1:0] mh, mh_prev, armed;
    logic [N-1:0] exp_out, exp_held;
    int           tt[N];
    int           run[N];
    logic [63:0]  pmask;

    function automatic bit due(int t);
        int u;
        if (t == INIT) return 1'b1;
        if (t < INIT) return 1'b0;
        u = t - INIT;
`ifdef KEY_REPEAT_ACCEL_EN
        if (u > ACCEL * RP) return ((u - ACCEL * RP) % FAST) == 0;
`endif
        return (u % RP) == 0;
    endfunction

    task automatic model_reset();
        raw_q.delete();
        for (int i = 0; i < SYNC; i++) raw_q.push_back('0);
        mh = '0; mh_prev = '0; armed = '0;
        exp_out = '0; exp_held = '0;
        for (int i = 0; i < N; i++) begin
            tt[i] = 0; run[i] = 0;
        end
    endtask

    task automatic model_step();
        logic [N-1:0] s;
        logic [N-1:0] eo;
        raw_q.push_front(key_push);
        s = raw_q[SYNC];
        void'(raw_q.pop_back());
        eo = '0;
        for (int i = 0; i < N; i++) begin
            if (!en) begin
                armed[i] = 1'b0;
            end else if (armed[i]) begin
                if (!mh[i]) armed[i] = 1'b0;
                else begin
                    tt[i]++;
                    eo[i] = due(tt[i]);
                end
            end else if (mh[i] && !mh_prev[i]) begin
                armed[i] = 1'b1;
                tt[i] = 0;
                eo[i] = 1'b1;
            end
            mh_prev[i] = mh[i];
            if (s[i] != mh[i]) begin
                run[i]++;
                if (run[i] == DB) begin
                    mh[i] = s[i];
                    run[i] = 0;
                end
            end else begin
                run[i] = 0;
            end
        end
        exp_out = eo;
        exp_held = mh;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        key_push = '0;
        en = 1'b1;
        RST = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        RST = 1'b1;
    endtask

    task automatic set_mask();
        int lst[$];
`ifdef KEY_REPEAT_ACCEL_EN
        lst = '{7, 17, 22, 27, 30, 33, 36};
`else
        lst = '{7, 17, 22, 27, 32, 37};
`endif
        pmask = '0;
        foreach (lst[k]) pmask[lst[k]] = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        RST = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (out !== 2'b00) begin
            n_bad++;
            $display("FAIL reset.out got=%b want=00", out);
        end
        n_cmp++;
        if (held !== 2'b00) begin
            n_bad++;
            $display("FAIL reset.held got=%b want=00", held);
        end
        do_reset();
        for (int c = 1; c <= 8; c++) begin
            tick();
            n_cmp++;
            if (out !== 2'b00 || held !== 2'b00) begin
                n_bad++;
                $display("FAIL reset.idle c=%0d got=%b/%b want=00/00", c, out, held);
            end
        end
    endtask

    task automatic test_hold_repeat();
        do_reset();
        key_push = 2'b01;
        for (int c = 1; c <= 40; c++) begin
            tick();
            n_cmp++;
            if (out[0] !== pmask[c]) begin
                n_bad++;
                $display("FAIL hold.out0 c=%0d got=%b want=%b", c, out[0], pmask[c]);
            end
            n_cmp++;
            if (out[1] !== 1'b0) begin
                n_bad++;
                $display("FAIL hold.out1 c=%0d got=%b want=0", c, out[1]);
            end
            n_cmp++;
            if (held[0] !== (c >= 6)) begin
                n_bad++;
                $display("FAIL hold.held0 c=%0d got=%b want=%b", c, held[0], c >= 6);
            end
            n_cmp++;
            if (out !== exp_out) begin
                n_bad++;
                $display("FAIL hold.model c=%0d got=%b want=%b", c, out, exp_out);
            end
        end
    endtask

    task automatic test_glitch();
        do_reset();
        for (int c = 0; c <= 30; c++) begin
            key_push[0] = (c < 3) || (c == 5) || (c == 6);
            tick();
            n_cmp++;
            if (held[0] !== 1'b0 || out[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL glitch c=%0d got=%b/%b want=0/0", c, held[0], out[0]);
            end
            n_cmp++;
            if (out !== exp_out || held !== exp_held) begin
                n_bad++;
                $display("FAIL glitch.model c=%0d got=%b/%b want=%b/%b",
                         c, out, held, exp_out, exp_held);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        key_push = 2'b11;
        for (int c = 1; c <= 40; c++) begin
            tick();
            // raw release at 9 lands as a debounced release at 15
            if (c == 9) key_push[1] = 1'b0;
            n_cmp++;
            if (out[0] !== pmask[c] || out[1] !== (c == 7)) begin
                n_bad++;
                $display("FAIL both.out c=%0d got=%b want=%b%b",
                         c, out, c == 7, pmask[c]);
            end
            n_cmp++;
            if (held[1] !== (c >= 6 && c < 15)) begin
                n_bad++;
                $display("FAIL both.held1 c=%0d got=%b want=%b",
                         c, held[1], c >= 6 && c < 15);
            end
            n_cmp++;
            if (out !== exp_out) begin
                n_bad++;
                $display("FAIL both.model c=%0d got=%b want=%b", c, out, exp_out);
            end
        end
    endtask

    task automatic test_enable();
        logic eh;
        do_reset();
        key_push = 2'b01;
        for (int c = 1; c <= 50; c++) begin
            tick();
            if (c == 12) en = 1'b0;
            if (c == 20) en = 1'b1;
            if (c == 30) key_push[0] = 1'b0;
            if (c == 36) key_push[0] = 1'b1;
            eh = (c >= 6 && c < 36) || (c >= 42);
            n_cmp++;
            if (out[0] !== (c == 7 || c == 43)) begin
                n_bad++;
                $display("FAIL en.out0 c=%0d got=%b want=%b", c, out[0], c == 7 || c == 43);
            end
            n_cmp++;
            if (held[0] !== eh) begin
                n_bad++;
                $display("FAIL en.held0 c=%0d got=%b want=%b", c, held[0], eh);
            end
            n_cmp++;
            if (out !== exp_out) begin
                n_bad++;
                $display("FAIL en.model c=%0d got=%b want=%b", c, out, exp_out);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        key_push = 2'b01;
        for (int c = 1; c <= 22; c++) tick();
        n_cmp++;
        if (out[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL areset.pre got=%b want=1", out[0]);
        end
        #2;
        RST = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (out !== 2'b00 || held !== 2'b00) begin
            n_bad++;
            $display("FAIL areset.async got=%b/%b want=00/00", out, held);
        end
        #2;
        RST = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            n_cmp++;
            if (out[0] !== (c == 7 || c == 17) || held[0] !== (c >= 6)) begin
                n_bad++;
                $display("FAIL areset.post c=%0d got=%b/%b want=%b/%b",
                         c, out[0], held[0], c == 7 || c == 17, c >= 6);
            end
            n_cmp++;
            if (out !== exp_out) begin
                n_bad++;
                $display("FAIL areset.model c=%0d got=%b want=%b", c, out, exp_out);
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] prev;
        do_reset();
        prev = '0;
        for (int c = 1; c <= 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 11) == 0) key_push[i] = ~key_push[i];
            end
            if ($urandom_range(0, 79) == 0) en = ~en;
            tick();
            n_cmp++;
            if (out !== exp_out || held !== exp_held) begin
                n_bad++;
                $display("FAIL rand.model c=%0d got=%b/%b want=%b/%b",
                         c, out, held, exp_out, exp_held);
            end
            n_cmp++;
            if ((out & prev) !== 2'b00) begin
                n_bad++;
                $display("FAIL rand.double c=%0d got=%b prev=%b want=no overlap", c, out, prev);
            end
            prev = out;
        end
    endtask

    initial begin
        set_mask();
        test_reset();
        test_hold_repeat();
        test_glitch();
        test_back_to_back();
        test_enable();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/key_repeat.md
Name: key_repeat

Overview:
- Multi-channel typematic key handler for the push-button inputs (move left/right/rotate/drop).
- Per channel it does three things:
  - synchronises and debounces the raw button;
  - emits a one-cycle pulse immediately on press;
  - after an initial hold delay, emits pulses at a fixed repeat rate until release.
- Sits between the board buttons and the game-control FSM, which consumes single-cycle move pulses.

Parameters:
- N_KEYS, 4: number of independent key channels.
- CNT_W, 32: width of the per-channel timing counters. Must hold the largest timing parameter.
- SYNC_STAGES, 2: flip-flop stages in the input synchroniser. Minimum 2.
- DEBOUNCE_CYC, 250000: cycles the synchronised input must differ from the stable level before the stable level flips (5 ms at 50 MHz). Minimum 1.
- INIT_DELAY, 15000000: cycles from the press pulse to the first repeat pulse (0.3 s). Minimum 1.
- REPEAT_PERIOD, 5000000: cycles between repeat pulses (0.1 s). Minimum 1.
- ACCEL_AFTER, 8: number of repeat pulses before switching to the fast period. Used only with KEY_REPEAT_ACCEL_EN.
- REPEAT_FAST, 2500000: accelerated repeat period. Used only with KEY_REPEAT_ACCEL_EN. Minimum 1.

Ports:
- clk  input  1  system clock.
- RST  input  1  asynchronous, active-low reset.
- en  input  1  global enable. Low forces every channel out of operation.
- key_push  input  N_KEYS  raw, asynchronous button levels; 1 = pressed.
- out  output  N_KEYS  one-cycle move pulse per channel; registered.
- held  output  N_KEYS  debounced stable level per channel; registered.

Behaviour:
- Reset (RST=0, asynchronous):
  - out=0, held=0;
  - synchroniser flops 0;
  - all counters 0;
  - all channel FSMs IDLE.
- Debounce, per channel:
  - sync = last synchroniser stage.
  - If sync == held, the debounce counter clears.
  - Otherwise it increments. On the edge where it equals DEBOUNCE_CYC-1 and sync still differs, held <= sync and the counter clears.
  - A glitch shorter than DEBOUNCE_CYC cycles never changes held.
- Per-channel FSM, states IDLE, DELAY, REPEAT, WAIT_REL. rcnt is the CNT_W-bit timing counter.
  - IDLE: when held rises and en=1, out pulses on the next edge (1 cycle), rcnt=0, go to DELAY.
  - DELAY: rcnt increments each cycle. At rcnt == INIT_DELAY-1: pulse, rcnt=0, go to REPEAT.
  - REPEAT: at rcnt == REPEAT_PERIOD-1: pulse, rcnt=0, stay in REPEAT.
  - WAIT_REL: no pulses. Go to IDLE when held=0.
  - held=0 in DELAY or REPEAT: go to IDLE, rcnt=0, no pulse. Release wins over a coincident terminal count.
  - en=0 in any state: out forced 0, rcnt=0. Next state is WAIT_REL if held=1, else IDLE.
  - A key still held when en returns does not pulse; a fresh press is required.
- Latency, raw edge to first out pulse: SYNC_STAGES + DEBOUNCE_CYC + 1 cycles.
  - Consecutive pulses while held: INIT_DELAY cycles from first to second, then REPEAT_PERIOD cycles between each.
- Channels are fully independent. Simultaneous presses on several channels each pulse in the same cycle; there is no arbitration.
- out is never high for two consecutive cycles on one channel. This requires every period parameter ≥ 2; a value of 1 is legal but gives a continuous pulse train.
- Counters compare by equality and never wrap while held. Parameter values exceeding 2^CNT_W-1 are illegal; flag with an elaboration-time check.

Optional Feature:
- Macro: KEY_REPEAT_ACCEL_EN.
- Defined:
  - each channel keeps a repeat-pulse counter, cleared on entry to DELAY;
  - once ACCEL_AFTER repeat pulses have been emitted in REPEAT, the terminal count becomes REPEAT_FAST-1 until release;
  - the counter saturates at ACCEL_AFTER.
- Undefined: no repeat-pulse counter exists. REPEAT_PERIOD applies throughout, and ACCEL_AFTER/REPEAT_FAST are ignored.

Decomposition:
- Package key_repeat_pkg holds:
  - the FSM state enum (IDLE, DELAY, REPEAT, WAIT_REL);
  - default timing constants, derived from CLK_HZ=50000000: debounce 5 ms, initial delay 0.3 s, repeat 0.1 s, fast repeat 0.05 s.
- Sub-module key_debounce: synchroniser plus debounce counter for one channel, with outputs held and rise. key_repeat instantiates it N_KEYS times in a generate loop; the FSM and rcnt stay in the top.

Test Plan (bench params: N_KEYS=2, SYNC_STAGES=2, DEBOUNCE_CYC=4, INIT_DELAY=10, REPEAT_PERIOD=5, ACCEL_AFTER=2, REPEAT_FAST=3):
1. Hold key_push[0]=1 from cycle 0 for 40 cycles:
   - held[0] rises at cycle 6;
   - out[0] pulses at 7, 17, 22, 27, 32, 37;
   - out[1] stays 0.
2. Glitches on key_push[0]: high 3 cycles, low 2, high 2, then low. held[0] and out[0] stay 0 throughout.
3. Press both keys in the same cycle: out[0] and out[1] pulse together at cycle 7. Release key 1 at cycle 15: no further out[1] pulses; key 0 repeats unaffected.
4. Drop en at cycle 12 and raise it at 20 with the key held:
   - no pulses from cycle 12 onward while the key stays held;
   - release for 6 cycles and re-press: new first pulse 7 cycles after the re-press.
5. Assert RST=0 mid-REPEAT: out and held drop to 0 asynchronously. On release with the key still high, the first pulse follows the full 7-cycle latency again.
6. With KEY_REPEAT_ACCEL_EN defined and key held: pulses at 7, 17, 22, 27, 30, 33, 36. Without the macro: 7, 17, 22, 27, 32, 37.
